// File: rtl/udma_uart_pkg.sv
// Shared constants and types for the uDMA UART receive/transmit path.
package udma_uart_pkg;

  // Width of one UART character.
  localparam int CHAR_W    = 8;
  // Width of the idle-timeout setting, in bit periods.
  localparam int TIMEOUT_W = 8;
  // Width of the bit-period divider.
  localparam int DIV_W     = 16;

  typedef logic [CHAR_W-1:0]    uart_char_t;
  typedef logic [TIMEOUT_W-1:0] uart_timeout_t;
  typedef logic [DIV_W-1:0]     uart_div_t;

endpackage

// File: rtl/udma_uart_rx_timeout.sv
// Character-timeout timer: counts idle bit periods after the last accepted
// character and emits a single-cycle pulse once the programmed count elapses.
module udma_uart_rx_timeout
  import udma_uart_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,    // accepted push: arm and restart
  input  logic                 run_i,      // data pending and line idle
  input  logic                 clear_i,    // flush/disable: disarm and restart
  input  logic [DIV_W-1:0]     div_i,      // bit period minus 1, in clk cycles
  input  logic [TIMEOUT_W-1:0] timeout_i,  // bit periods; 0 disables
  output logic                 pulse_o
);

  logic [DIV_W-1:0]     presc_cnt;
  logic [TIMEOUT_W-1:0] bit_cnt;
  logic                 armed;
  logic                 counting;
  logic                 bit_tick;
  logic                 reached;

  assign counting = armed && run_i && (timeout_i != '0);
  // '>=' lets a mid-count reduction of div/timeout take effect at the next compare.
  assign bit_tick = (presc_cnt >= div_i);
  assign reached  = ({1'b0, bit_cnt} + 9'd1) >= {1'b0, timeout_i};

  // Prescaler, bit counter, armed flag and registered pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_cnt <= '0;
      bit_cnt   <= '0;
      armed     <= 1'b0;
      pulse_o   <= 1'b0;
    end else begin
      pulse_o <= 1'b0;
      if (clear_i) begin
        presc_cnt <= '0;
        bit_cnt   <= '0;
        armed     <= 1'b0;
      end else if (start_i) begin
        presc_cnt <= '0;
        bit_cnt   <= '0;
        armed     <= 1'b1;
      end else if (counting) begin
        if (bit_tick) begin
          presc_cnt <= '0;
          if (reached) begin
            bit_cnt <= '0;
            armed   <= 1'b0;
            pulse_o <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end else begin
          presc_cnt <= presc_cnt + 16'd1;
        end
      end else begin
        presc_cnt <= '0;
        bit_cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/udma_uart_rx_buffer.sv
// Receive buffer between the UART receiver and the uDMA RX channel: a small
// FIFO that always accepts characters, with sticky overrun and idle timeout.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never depends on ready, and data is stable while valid
// is high and not yet accepted. On the receiver side, ready is simply the
// enable, so a character arriving while full is dropped (overrun) instead of
// stalling the receiver.
module udma_uart_rx_buffer
  import udma_uart_pkg::*;
#(
  parameter  int DEPTH     = 8,
  localparam int LOG_DEPTH = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [15:0]          cfg_div_i,
  input  logic [7:0]           cfg_timeout_i,
  input  logic                 flush_i,
  input  logic                 err_clr_i,
  input  logic [7:0]           uart_data_i,
  input  logic                 uart_valid_i,
  output logic                 uart_ready_o,
  input  logic                 uart_busy_i,
  output logic [7:0]           data_rx_o,
  output logic                 data_rx_valid_o,
  input  logic                 data_rx_ready_i,
  output logic [LOG_DEPTH:0]   fill_o,
  output logic                 overrun_o,
  output logic                 timeout_o
);

  localparam logic [LOG_DEPTH:0]   FILL_FULL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   FILL_ONE  = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE   = LOG_DEPTH'(1);

  logic [CHAR_W-1:0]    mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   fill;

  logic flush_all;
  logic full;
  logic empty;
  logic push_req;
  logic pop_ok;
  logic push_ok;
  logic drop;
  logic timer_run;

  assign flush_all = flush_i || !cfg_en_i;
  assign full      = (fill == FILL_FULL);
  assign empty     = (fill == '0);
  assign push_req  = uart_valid_i && uart_ready_o;
  assign pop_ok    = data_rx_valid_o && data_rx_ready_i && !flush_all;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_req && (!full || pop_ok) && !flush_all;
  assign drop      = push_req && full && !pop_ok && !flush_all;
  assign timer_run = !empty && !uart_busy_i;

  assign uart_ready_o    = cfg_en_i;
  assign data_rx_valid_o = !empty;
  assign data_rx_o       = mem[rd_ptr];
  assign fill_o          = fill;

  // Character storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= uart_data_i;
    end
  end

  // Pointers and occupancy; flush or disable empties the FIFO.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush_all) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
    end
  end

  // Sticky overrun; clear wins over a same-cycle drop, flush leaves it alone.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overrun_o <= 1'b0;
    end else if (err_clr_i) begin
      overrun_o <= 1'b0;
    end else if (drop) begin
      overrun_o <= 1'b1;
    end
  end

  udma_uart_rx_timeout u_timeout (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .start_i   (push_ok),
    .run_i     (timer_run),
    .clear_i   (flush_all),
    .div_i     (cfg_div_i),
    .timeout_i (cfg_timeout_i),
    .pulse_o   (timeout_o)
  );

endmodule

// File: doc/udma_uart_rx_buffer.md
Name: udma_uart_rx_buffer

Overview:
- Downstream stage of the UART receiver: consumes its 8-bit data/valid/ready stream and the receiver's busy flag.
- Buffers received characters in a small FIFO and presents them to the uDMA RX channel over a valid/ready stream.
- Always accepts characters, so the receiver never stalls long enough to miss the next start bit.
- Flags overrun when full and raises a one-shot character-timeout event when the line idles with data pending.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- LOG_DEPTH, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_en_i  in  1  enable; when low, FIFO is emptied and the timer is cleared
- cfg_div_i  in  16  bit period minus 1, in clk cycles; same value as given to the receiver
- cfg_timeout_i  in  8  idle timeout in bit periods; 0 disables the timeout
- flush_i  in  1  one-cycle pulse that empties the FIFO
- err_clr_i  in  1  clears overrun_o
- uart_data_i  in  8  character from the receiver
- uart_valid_i  in  1  character valid
- uart_ready_o  out  1  equals cfg_en_i
- uart_busy_i  in  1  receiver not idle
- data_rx_o  out  8  head-of-FIFO character
- data_rx_valid_o  out  1  FIFO not empty
- data_rx_ready_i  in  1  uDMA consumes the head entry
- fill_o  out  LOG_DEPTH+1  current occupancy
- overrun_o  out  1  sticky: a character was dropped
- timeout_o  out  1  one-cycle timeout event

Behaviour:
- Reset: pointers 0, fill_o=0, data_rx_valid_o=0, overrun_o=0, timeout_o=0, timer cleared. data_rx_o content is don't-care while valid is 0.
- Push: uart_valid_i && uart_ready_o && !full. Data is written at wr_ptr and appears at data_rx_o the next cycle if the FIFO was empty (1-cycle latency).
- Pop: data_rx_valid_o && data_rx_ready_i. rd_ptr advances, and the next entry is visible the following cycle.
- Full and push with no pop in the same cycle: the character is dropped and overrun_o sets on the next edge. uart_ready_o stays high, so the receiver does not wait.
- Full with push and pop in the same cycle: the push is accepted, fill stays at DEPTH, no overrun.
- Empty with a push: pop is impossible that cycle. There is no fall-through; valid rises the next cycle.
- Pointers wrap naturally at DEPTH. full is fill==DEPTH; empty is fill==0.
- overrun_o: err_clr_i has priority over a set in the same cycle.
- Flush (flush_i=1 or cfg_en_i=0):
  - pointers and fill go to 0 on the next edge;
  - a push or pop in the same cycle is discarded, with no overrun;
  - the timer is cleared and disarmed;
  - overrun_o is unaffected.
- Timeout timer:
  - A prescaler counts 0..cfg_div_i; each wrap is one bit tick.
  - A bit counter counts ticks.
  - The timer runs only when armed && fill!=0 && !uart_busy_i && cfg_timeout_i!=0.
  - Otherwise, and on every accepted push, the prescaler and bit counter reset to 0.
  - Arming: armed sets on an accepted push.
  - Firing: when the bit counter reaches cfg_timeout_i, timeout_o pulses for exactly 1 cycle, armed clears and the counters reset.
  - No further pulse occurs until a new push.
  - A pop does not disarm. FIFO draining to empty stops the timer without firing.
- Timing: the first pulse after the last push comes (cfg_div_i+1)*cfg_timeout_i cycles after the timer starts running, ±1 cycle for the registered output.
- cfg_div_i or cfg_timeout_i changing mid-count takes effect at the next compare. No reset of the count is required.

Decomposition:
- Package udma_uart_pkg holds the character width constant (8) and the timeout width constant (8), shared with the receiver and transmitter.
- One sub-module, udma_uart_rx_timeout: prescaler, bit counter, armed flag and pulse generation. Inputs: start, run, clear, div, timeout. Output: pulse.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset, then push 0x55, 0xAA, 0x0F with data_rx_ready_i=1 → output order 0x55, 0xAA, 0x0F; each valid 1 cycle after its push; fill_o ends 0.
- data_rx_ready_i=0, push 9 bytes 0x00..0x08, DEPTH=8 → fill_o=8, overrun_o=1, uart_ready_o stays 1; drain yields 0x00..0x07; err_clr_i clears overrun_o.
- FIFO full, push 0x77 and pop in the same cycle → no overrun, fill_o stays 8, 0x77 is the last character drained.
- cfg_div_i=3, cfg_timeout_i=4, one push, uart_busy_i=0 → single timeout_o pulse at 16±1 cycles after the push; no second pulse; a new push re-arms.
- Timer running and uart_busy_i raised mid-count → no pulse; count restarts from 0 after busy falls. cfg_timeout_i=0 → never pulses.
- 3 entries queued, flush_i pulsed together with a push → fill_o=0 next cycle, data_rx_valid_o=0, no overrun, no timeout.
